// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle instruction sequencer owning the PC and all datapath write enables
// Define CPU_SEQ_PERF_EN to add the cycle_count / retired_count performance counters.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  opcode,
  output logic [15:0] inst_address,
  output logic        ir_load,
  output logic [1:0]  alu_op,
  output logic        reg_write_en,
  output logic        reg_write_src,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic        busy,
  output logic        halted,
`ifdef CPU_SEQ_PERF_EN
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count,
`endif
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t      cur, nxt;
  logic [2:0]  op_q, op_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] pc_d;
  logic        honoured;
  logic        retire;

  function automatic logic [1:0] alu_map(input logic [2:0] op);
    case (op)
      OP_SUB:  alu_map = 2'b01;
      OP_AND:  alu_map = 2'b10;
      OP_OR:   alu_map = 2'b11;
      default: alu_map = 2'b00;
    endcase
  endfunction

  always_comb begin
    nxt      = cur;
    op_d     = op_q;
    wait_d   = wait_q;
    pc_d     = inst_address;
    honoured = 1'b0;
    retire   = 1'b0;
    case (cur)
      S_IDLE, S_HALTED: begin
        if (start) begin
          nxt      = S_FETCH;
          pc_d     = RESET_PC;
          honoured = 1'b1;
        end
      end
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        nxt  = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (op_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR: nxt = S_WRITEBACK;
          OP_LOAD, OP_STORE: begin
            nxt    = S_MEMORY;
            wait_d = WAIT_INIT;
          end
          OP_HALT: begin
            nxt    = S_HALTED;
            retire = 1'b1;
          end
          default: begin
            nxt    = S_FETCH;
            pc_d   = inst_address + 16'd1;
            retire = 1'b1;
          end
        endcase
      end
      S_MEMORY: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (op_q == OP_STORE) begin
          nxt    = S_FETCH;
          pc_d   = inst_address + 16'd1;
          retire = 1'b1;
        end else begin
          nxt = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        nxt    = S_FETCH;
        pc_d   = inst_address + 16'd1;
        retire = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up exactly with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur           <= S_IDLE;
      op_q          <= OP_NOP;
      wait_q        <= 4'd0;
      inst_address  <= RESET_PC;
      ir_load       <= 1'b0;
      alu_op        <= 2'b00;
      reg_write_en  <= 1'b0;
      reg_write_src <= 1'b0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
    end else begin
      cur           <= nxt;
      op_q          <= op_d;
      wait_q        <= wait_d;
      inst_address  <= pc_d;
      ir_load       <= (nxt == S_FETCH);
      alu_op        <= alu_map(op_d);
      reg_write_en  <= (nxt == S_WRITEBACK);
      reg_write_src <= (nxt == S_WRITEBACK) && (op_d == OP_LOAD);
      mem_read_en   <= (nxt == S_MEMORY) && (op_d == OP_LOAD);
      mem_write_en  <= (nxt == S_MEMORY) && (op_d == OP_STORE) && (wait_d == 4'd0);
      busy          <= (nxt != S_IDLE) && (nxt != S_HALTED);
      halted        <= (nxt == S_HALTED);
    end
  end

  assign state = cur;

`ifdef CPU_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count   <= 32'd0;
      retired_count <= 32'd0;
    end else if (honoured) begin
      cycle_count   <= 32'd0;
      retired_count <= 32'd0;
    end else begin
      if (busy) cycle_count <= cycle_count + 32'd1;
      if (retire) retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - bench for cpu_sequencer: instruction-level model plus directed literal checks
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  opcode;

  logic [15:0] a_addr, b_addr;
  logic        a_irl, b_irl, a_rwe, b_rwe, a_rws, b_rws, a_mre, b_mre, a_mwe, b_mwe;
  logic        a_bsy, b_bsy, a_hlt, b_hlt;
  logic [1:0]  a_alu, b_alu;
  logic [2:0]  a_st, b_st;
  logic [31:0] a_cc, b_cc, a_rc, b_rc;

  int tests;
  int fails;
  int cyc_n;

  cpu_sequencer #(.RESET_PC(16'hFFFF), .MEM_WAIT(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .inst_address(a_addr), .ir_load(a_irl), .alu_op(a_alu),
    .reg_write_en(a_rwe), .reg_write_src(a_rws),
    .mem_read_en(a_mre), .mem_write_en(a_mwe),
    .busy(a_bsy), .halted(a_hlt),
`ifdef CPU_SEQ_PERF_EN
    .cycle_count(a_cc), .retired_count(a_rc),
`endif
    .state(a_st)
  );

  cpu_sequencer #(.RESET_PC(16'h0000), .MEM_WAIT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .inst_address(b_addr), .ir_load(b_irl), .alu_op(b_alu),
    .reg_write_en(b_rwe), .reg_write_src(b_rws),
    .mem_read_en(b_mre), .mem_write_en(b_mwe),
    .busy(b_bsy), .halted(b_hlt),
`ifdef CPU_SEQ_PERF_EN
    .cycle_count(b_cc), .retired_count(b_rc),
`endif
    .state(b_st)
  );

`ifndef CPU_SEQ_PERF_EN
  assign a_cc = 32'd0;
  assign a_rc = 32'd0;
  assign b_cc = 32'd0;
  assign b_rc = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level model: mode 0 idle, 1 running, 2 halted; k = cycle number within the instruction.
  int          m_mode [2];
  int          m_k    [2];
  logic [2:0]  m_op   [2];
  logic [15:0] m_pc   [2];
  logic [31:0] m_cyc  [2];
  logic [31:0] m_ret  [2];

  function automatic int w_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [15:0] rp_of(input int i);
    return (i == 0) ? 16'hFFFF : 16'h0000;
  endfunction

  function automatic int ilen(input logic [2:0] op, input int w);
    case (op)
      3'd0, 3'd7: return 3;
      3'd5:       return 5 + w;
      3'd6:       return 4 + w;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [2:0] op);
    case (op)
      3'd2:    return 2'b01;
      3'd3:    return 2'b10;
      3'd4:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] <= 0;
        m_k[i]    <= 0;
        m_op[i]   <= 3'd0;
        m_pc[i]   <= rp_of(i);
        m_cyc[i]  <= 32'd0;
        m_ret[i]  <= 32'd0;
      end else if (m_mode[i] != 1) begin
        if (start) begin
          m_mode[i] <= 1;
          m_k[i]    <= 1;
          m_pc[i]   <= rp_of(i);
          m_cyc[i]  <= 32'd0;
          m_ret[i]  <= 32'd0;
        end
      end else begin
        m_cyc[i] <= m_cyc[i] + 32'd1;
        if (m_k[i] == 2) begin
          m_op[i] <= opcode;
          m_k[i]  <= 3;
        end else if (m_k[i] >= 3 && m_k[i] == ilen(m_op[i], w_of(i))) begin
          m_ret[i] <= m_ret[i] + 32'd1;
          if (m_op[i] == 3'd7) begin
            m_mode[i] <= 2;
            m_k[i]    <= 0;
          end else begin
            m_k[i]  <= 1;
            m_pc[i] <= m_pc[i] + 16'd1;
          end
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [15:0] addr, input logic irl, input logic [1:0] alu,
                          input logic rwe, input logic rws, input logic mre, input logic mwe,
                          input logic bsy, input logic hlt, input logic [2:0] st,
                          input logic [31:0] cc, input logic [31:0] rc);
    int         k, w, len, est;
    logic [2:0] op;
    logic       run, ld, stq, e_rwe;
    k   = m_k[i];
    w   = w_of(i);
    op  = m_op[i];
    run = (m_mode[i] == 1);
    len = ilen(op, w);
    ld  = (op == 3'd5);
    stq = (op == 3'd6);
    e_rwe = run && k >= 4 && k == len && op >= 3'd1 && op <= 3'd5;
    if (m_mode[i] == 0) est = 0;
    else if (m_mode[i] == 2) est = 6;
    else if (k <= 3) est = k;
    else if ((ld || stq) && k <= 4 + w) est = 4;
    else est = 5;
    chk("inst_address", i, 32'(addr), 32'(m_pc[i]));
    chk("state", i, 32'(st), 32'(est));
    chk("ir_load", i, 32'(irl), 32'(run && k == 1));
    chk("busy", i, 32'(bsy), 32'(run));
    chk("halted", i, 32'(hlt), 32'(m_mode[i] == 2));
    chk("mem_read_en", i, 32'(mre), 32'(run && ld && k >= 4 && k <= 4 + w));
    chk("mem_write_en", i, 32'(mwe), 32'(run && stq && k == 4 + w));
    chk("reg_write_en", i, 32'(rwe), 32'(e_rwe));
    chk("reg_write_src", i, 32'(rws), 32'(e_rwe && ld));
    chk("wen_exclusive", i, 32'(rwe & mwe), 32'd0);
    if (run && k >= 3) chk("alu_op", i, 32'(alu), 32'(alu_of(op)));
`ifdef CPU_SEQ_PERF_EN
    chk("cycle_count", i, cc, m_cyc[i]);
    chk("retired_count", i, rc, m_ret[i]);
`endif
  endtask

  always @(negedge clk) begin
    cmp_inst(0, a_addr, a_irl, a_alu, a_rwe, a_rws, a_mre, a_mwe, a_bsy, a_hlt, a_st, a_cc, a_rc);
    cmp_inst(1, b_addr, b_irl, b_alu, b_rwe, b_rws, b_mre, b_mwe, b_bsy, b_hlt, b_st, b_cc, b_rc);
  end

  task automatic step;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic pulse_start(input logic [2:0] op);
    opcode = op;
    start  = 1'b1;
    step();
    start  = 1'b0;
    cyc_n  = 1;
  endtask

  task automatic to_cycle(input int n);
    while (cyc_n < n) step();
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    cyc_n  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    opcode = 3'd0;
    repeat (3) step();
    chk("rst_state", 0, 32'(a_st), 32'd0);
    chk("rst_addr", 0, 32'(a_addr), 32'hFFFF);
    chk("rst_addr", 1, 32'(b_addr), 32'h0000);
    chk("rst_strobes", 1, {26'd0, b_irl, b_alu, b_rwe, b_mre, b_mwe}, 32'd0);
    chk("rst_busy", 1, 32'(b_bsy | b_hlt | b_rws), 32'd0);
    rst = 1'b0;
    step();

    // ALU sequence, then HALT; a start while busy is ignored
    pulse_start(3'b001);
    chk("alu_c1_addr", 1, 32'(b_addr), 32'h0000);
    chk("alu_c1_irl", 1, 32'(b_irl), 32'd1);
    chk("alu_c1_addr", 0, 32'(a_addr), 32'hFFFF);
    to_cycle(4);
    chk("alu_c4_rwe", 1, 32'(b_rwe), 32'd1);
    chk("alu_c4_op", 1, 32'(b_alu), 32'd0);
    chk("alu_c4_src", 1, 32'(b_rws), 32'd0);
    to_cycle(5);
    chk("alu_c5_addr", 1, 32'(b_addr), 32'h0001);
    chk("alu_c5_rwe", 1, 32'(b_rwe), 32'd0);
    chk("pc_wrap", 0, 32'(a_addr), 32'h0000);
    opcode = 3'b010;
    to_cycle(8);
    chk("sub_op", 1, 32'(b_alu), 32'd1);
    opcode = 3'b011;
    to_cycle(12);
    chk("and_op", 1, 32'(b_alu), 32'd2);
    opcode = 3'b100;
    to_cycle(16);
    chk("or_op", 1, 32'(b_alu), 32'd3);
    opcode = 3'b111;
    to_cycle(17);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_ign", 1, 32'(b_st), 32'd2);
    chk("busy_start_addr", 1, 32'(b_addr), 32'h0004);
    to_cycle(22);
    chk("halt_addr", 1, 32'(b_addr), 32'h0004);
    chk("halt_addr", 0, 32'(a_addr), 32'h0003);

    // HALT directly: halted from cycle 4, restart reloads RESET_PC
    pulse_start(3'b111);
    chk("restart_addr", 1, 32'(b_addr), 32'h0000);
    chk("restart_addr", 0, 32'(a_addr), 32'hFFFF);
    to_cycle(3);
    chk("halt_c3", 1, 32'(b_hlt), 32'd0);
    to_cycle(4);
    chk("halt_c4", 1, 32'(b_hlt), 32'd1);
    chk("halt_c4_busy", 0, 32'(a_bsy), 32'd0);
    chk("halt_c4_addr", 0, 32'(a_addr), 32'hFFFF);

    // STORE: dut_a waits two extra cycles, dut_b writes in cycle 4
    pulse_start(3'b110);
    to_cycle(4);
    chk("st_c4_wr", 1, 32'(b_mwe), 32'd1);
    chk("st_c4_wr", 0, 32'(a_mwe), 32'd0);
    to_cycle(5);
    chk("st_c5_wr", 0, 32'(a_mwe), 32'd0);
    chk("st_c5_next", 1, 32'(b_addr), 32'h0001);
    to_cycle(6);
    chk("st_c6_wr", 0, 32'(a_mwe), 32'd1);
    chk("st_c6_rwe", 0, 32'(a_rwe), 32'd0);
    to_cycle(7);
    chk("st_c7_addr", 0, 32'(a_addr), 32'h0000);
    chk("st_c7_irl", 0, 32'(a_irl), 32'd1);

    // Asynchronous reset in the final MEMORY cycle of the second store
    to_cycle(12);
    chk("st_c12_wr", 0, 32'(a_mwe), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_wr", 0, 32'(a_mwe), 32'd0);
    chk("async_rst_state", 0, 32'(a_st), 32'd0);
    chk("async_rst_addr", 0, 32'(a_addr), 32'hFFFF);
    step();
    rst = 1'b0;
    step();
    step();
    chk("post_rst_idle", 0, 32'(a_st), 32'd0);

    // LOAD with opcode changed after DECODE
    pulse_start(3'b101);
    to_cycle(3);
    opcode = 3'b110;
    to_cycle(4);
    chk("ld_c4_rd", 1, 32'(b_mre), 32'd1);
    chk("ld_c4_rd", 0, 32'(a_mre), 32'd1);
    opcode = 3'b111;
    to_cycle(5);
    chk("ld_c5_rwe", 1, 32'(b_rwe), 32'd1);
    chk("ld_c5_src", 1, 32'(b_rws), 32'd1);
    to_cycle(7);
    chk("ld_c7_src", 0, 32'(a_rws), 32'd1);
    to_cycle(11);
    chk("ld_then_halt", 1, 32'(b_hlt), 32'd1);
    chk("ld_then_halt", 0, 32'(a_hlt), 32'd1);

    // NOP from RESET_PC=FFFF wraps to 0000
    pulse_start(3'b000);
    to_cycle(4);
    chk("nop_wrap", 0, 32'(a_addr), 32'h0000);
    chk("nop_next", 1, 32'(b_addr), 32'h0001);
`ifdef CPU_SEQ_PERF_EN
    chk("perf_cycles", 0, a_cc, 32'd3);
    chk("perf_retired", 0, a_rc, 32'd1);
`endif
    opcode = 3'b111;
    to_cycle(9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the single-issue CPU. It owns the program counter that addresses InstructionMemory. It steps each instruction through fetch, decode, execute, memory and writeback. Per phase, it raises the enables for the register file (`write_en`) and DataMemory (`write_en`), using the 3-bit opcode returned by the Decoder. It is the only block that asserts write enables in the datapath.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC value loaded at reset and on every start.
- `MEM_WAIT`, 0: extra DataMemory wait cycles per load/store, range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; honoured only in IDLE or HALTED.
- `opcode`  in  3  Decoder opcode for the current instruction.
- `inst_address`  out  16  PC, drives InstructionMemory `inst_address`.
- `ir_load`  out  1  high in FETCH; instruction register capture strobe.
- `alu_op`  out  2  00 add, 01 sub, 10 and, 11 or; held from DECODE to the end of the instruction.
- `reg_write_en`  out  1  register-file write strobe.
- `reg_write_src`  out  1  0 = ALU result, 1 = DataMemory `read_data`.
- `mem_read_en`  out  1  DataMemory read qualifier.
- `mem_write_en`  out  1  DataMemory write strobe.
- `busy`  out  1  high in every state except IDLE and HALTED.
- `halted`  out  1  high in HALTED.
- `state`  out  3  encoded FSM state, for debug.

## Operation
- Opcode map: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 LOAD, 110 STORE, 111 HALT.
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6.
- IDLE: a start pulse loads PC=`RESET_PC` and moves to FETCH.
- FETCH: `ir_load`=1. Next state is DECODE.
- DECODE: `opcode` is latched into an internal op register. `opcode` is ignored after this cycle.
- EXECUTE, by latched op:
  - ADD/SUB/AND/OR go to WRITEBACK.
  - LOAD/STORE go to MEMORY, with the wait counter loaded to `MEM_WAIT`.
  - NOP goes to FETCH, with PC+1.
  - HALT goes to HALTED; PC is not incremented.
- MEMORY: held until the wait counter reaches 0; the counter decrements each cycle.
  - LOAD: `mem_read_en`=1 for every MEMORY cycle; then WRITEBACK.
  - STORE: `mem_write_en`=1 only in the final MEMORY cycle (counter = 0); then FETCH with PC+1.
- WRITEBACK: `reg_write_en`=1 for exactly one cycle; `reg_write_src`=1 for LOAD, 0 otherwise. Then FETCH with PC+1.
- HALTED: held indefinitely. A start pulse reloads `RESET_PC` and goes to FETCH.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000, and no flag is raised.
- `start` in any busy state is ignored and not queued.
- Write enables are mutually exclusive. `reg_write_en` and `mem_write_en` are never high together.

## Timing
- Reset values: `state`=IDLE, `inst_address`=`RESET_PC`; `ir_load`, `alu_op`, `reg_write_en`, `reg_write_src`, `mem_read_en`, `mem_write_en`, `busy` and `halted` are all 0. The wait counter and op register are 0.
- Outputs are decoded from registered state plus the latched op (Moore). There is no combinational path from `opcode` or `start` to any output.
- Cycles per instruction:
  - NOP: 3.
  - ALU ops: 4.
  - STORE: 4+`MEM_WAIT`.
  - LOAD: 5+`MEM_WAIT`.
  - HALT: 3 cycles to reach HALTED.
- The PC update is visible on `inst_address` in the first FETCH cycle of the next instruction.
- Reset asserted mid-instruction: all outputs go to their reset values immediately, without waiting for `clk`. An in-progress STORE or LOAD writeback is aborted, with no partial strobe. The first `clk` edge after `rst` falls sees IDLE.

## Configuration
- `CPU_SEQ_PERF_EN` defined: two extra outputs are added, `cycle_count` (32, out) and `retired_count` (32, out).
  - Both reset to 0.
  - `cycle_count` increments every cycle `busy`=1.
  - `retired_count` increments on every transition back to FETCH and on entry to HALTED.
  - Both wrap modulo 2^32.
  - Both clear on each honoured start.
- Not defined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Reset, then start, with `opcode`=001 held: `inst_address`=0. FETCH, DECODE, EXECUTE run, then WRITEBACK in cycle 4 with `reg_write_en`=1 for one cycle, `alu_op`=00, `reg_write_src`=0. Next FETCH shows `inst_address`=1.
- `MEM_WAIT`=2, `opcode`=110: MEMORY lasts 3 cycles. `mem_write_en`=1 only in the third MEMORY cycle. `reg_write_en` stays 0. The next instruction begins in cycle 7 with PC+1.
- `MEM_WAIT`=0, `opcode`=101: `mem_read_en`=1 in cycle 4. Cycle 5 has `reg_write_en`=1 and `reg_write_src`=1. Toggling `opcode` after DECODE has no effect.
- `opcode`=111: `halted`=1 and `busy`=0 from cycle 4. `inst_address` is unchanged. Start then reloads `RESET_PC`, and a start while busy is ignored.
- `rst` pulsed during the final MEMORY cycle of a STORE: `mem_write_en` drops to 0 before the next edge. `state`=0 and `inst_address`=`RESET_PC`.
- `RESET_PC`=16'hFFFF with NOP: the next `inst_address`=16'h0000. With `CPU_SEQ_PERF_EN` defined: `cycle_count`=3 and `retired_count`=1 after that NOP.
